load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage sequencer sitting directly upstream of the word-only data RAM.
//  Turns pipeline load/store requests (byte/half/word, signed/unsigned) into word RAM cycles.
//  Sub-word stores run as read-modify-write; loads are lane-extracted and extended.
//  Misaligned accesses are flagged with no RAM access.
// PARAMETERS
//  BIG_ENDIAN  1  1: byte at addr[1:0]=0 is bits[31:24]; 0: bits[7:0]
// PORTS
//  clock       in   1   system clock; all state on posedge
//  reset_n     in   1   asynchronous, active-low reset
//  req_valid   in   1   request present; held stable until accepted
//  req_ready   out  1   high only in IDLE; accept = req_valid & req_ready @posedge
//  req_write   in   1   1 = store, 0 = load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid  out  1   one-cycle pulse: request complete
//  resp_err    out  1   valid with resp_valid: misaligned or illegal size
//  load_data   out  32  extended load result, valid with resp_valid
//  mem_addr    out  32  word address {addr_q[31:2],2'b00} to RAM
//  mem_wdata   out  32  merged write word
//  mem_write   out  1   RAM write strobe (RAM writes on posedge)
//  mem_read    out  1   RAM read strobe (RAM returns data by next posedge)
//  mem_rdata   in   32  RAM read word
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid/resp_err/mem_write/mem_read=0; load_data, mem_addr, mem_wdata=0.
//  States: IDLE, RD, WR, RESP. On accept, latch addr/size/signed/write/wdata into *_q regs.
//  IDLE -> RESP with err=1 if size=11, half with addr[0]=1, or word with addr[1:0]!=0.
//  IDLE -> RD for loads and byte/half stores; IDLE -> WR for aligned word stores.
//  RD: mem_read=1; @posedge capture mem_rdata into rdata_q; load -> RESP, store -> WR.
//  WR: mem_write=1; mem_wdata = rdata_q with addressed lane(s) replaced by wdata_q
//      (word store: wdata_q unmodified); @posedge -> RESP.
//  RESP: resp_valid=1 for exactly one cycle, resp_err and load_data registered; -> IDLE.
//  mem_read and mem_write are decoded from state only, never both high; both 0 in IDLE/RESP.
//  Latency accept-edge to resp_valid: load 2 cycles (RD, RESP), word store 2 (WR, RESP),
//    sub-word store 3 (RD, WR, RESP), error 1 (RESP).
//  Throughput: next request accepted no earlier than the cycle after RESP (ready in IDLE only).
//  Lane select (BIG_ENDIAN=1): byte k = bits[31-8k -: 8]; half addr[1]=0 -> [31:16], 1 -> [15:0].
//  load_data: byte/half extended per signed_q; word loaded as-is; on error load_data=0.
//  No RAM strobe is ever asserted for an errored request; req_wdata ignored for loads.
//  req_valid while not ready: ignored, no state change.
//  Async reset mid-operation: state->IDLE immediately; mem_write drops before the next edge,
//    so an in-flight write is abandoned (not partial); no resp_valid for the aborted request.
// TESTING
//  RAM[0x10]=0x8899AABB; lb 0x11 (signed) -> resp_valid after 2 cycles, load_data=0xFFFFFF99.
//  Same word, lbu 0x13 -> load_data=0x000000BB; lhu 0x12 -> 0x0000AABB; lh 0x10 -> 0xFFFF8899.
//  sb 0x12 wdata=0x000000CC -> RD then WR with mem_wdata=0x8899CCBB, resp 3 cycles; lw 0x10 -> 0x8899CCBB.
//  sw 0x20 wdata=0xDEADBEEF -> mem_read never high, WR then RESP; lw 0x20 -> 0xDEADBEEF.
//  lh 0x21 and sw 0x22 and size=11 -> resp_err=1 one cycle after accept, mem_read=mem_write=0 throughout.
//  sh 0x30 then pull reset_n low during WR -> mem_write=0 same cycle, RAM[0x30] unchanged, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage sequencer in front of a word-only data RAM: sub-word stores run as
// read-modify-write, loads are lane-extracted and extended, misaligned requests error out.
`timescale 1ns/1ps
module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, load_data_q;
  logic [1:0]  size_q;
  logic        signed_q, write_q, err_q;

  logic        accept, misalign;
  logic [4:0]  shamt;
  logic [31:0] lane_mask, shifted, load_ext;

  assign accept   = req_valid && (state_q == IDLE);
  assign misalign = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Bit offset of the addressed lane; byte k in big-endian sits at 8*(3-k), i.e. 8*~k.
  always_comb begin
    shamt     = '0;
    lane_mask = '1;
    case (size_q)
      2'b00: begin
        shamt     = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
        lane_mask = 32'h0000_00FF << shamt;
      end
      2'b01: begin
        shamt     = BIG_ENDIAN ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
        lane_mask = 32'h0000_FFFF << shamt;
      end
      default: begin
        shamt     = '0;
        lane_mask = '1;
      end
    endcase
  end

  assign shifted = mem_rdata >> shamt;

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      load_data_q <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q      <= req_addr;
        wdata_q     <= req_wdata;
        size_q      <= req_size;
        signed_q    <= req_signed;
        write_q     <= req_write;
        err_q       <= misalign;
        load_data_q <= '0;
      end
      if (state_q == RD) begin
        rdata_q <= mem_rdata;
        if (!write_q) load_data_q <= load_ext;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misalign)                            state_d = RESP;
          else if (req_write && req_size == 2'b10) state_d = WR;
          else                                     state_d = RD;
        end
      end
      RD: begin
        mem_read = 1'b1;
        state_d  = write_q ? WR : RESP;
      end
      WR: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_data = load_data_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = (rdata_q & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word RAM model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_write, mem_read;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram [0:63];
  int unsigned errors = 0;
  int unsigned checks = 0;

  load_store_unit #(.BIG_ENDIAN(1'b1)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .load_data  (load_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clock) if (mem_write) ram[mem_addr[7:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to its response, recording strobe activity.
  task automatic run_req(input string tag, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_ld,
                         input logic exp_rd, input logic exp_wr, input logic [31:0] exp_wdata);
    int lat;
    logic saw_rd, saw_wr, both, rdy_busy;
    logic [31:0] wr_seen;
    saw_rd = 1'b0; saw_wr = 1'b0; both = 1'b0; rdy_busy = 1'b0; wr_seen = '0;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    check({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0; req_wdata = 32'hA5A5_5A5A;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      if (mem_read)  saw_rd = 1'b1;
      if (mem_write) begin saw_wr = 1'b1; wr_seen = mem_wdata; end
      if (mem_read && mem_write) both = 1'b1;
      if (req_ready) rdy_busy = 1'b1;
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/err"}, {31'b0, resp_err}, {31'b0, exp_err});
    if (!w || exp_err) check({tag, "/load_data"}, load_data, exp_ld);
    check({tag, "/saw_read"}, {31'b0, saw_rd}, {31'b0, exp_rd});
    check({tag, "/saw_write"}, {31'b0, saw_wr}, {31'b0, exp_wr});
    check({tag, "/strobes_in_resp"}, {30'b0, mem_read, mem_write}, 32'd0);
    check({tag, "/both_strobes"}, {31'b0, both}, 32'd0);
    check({tag, "/ready_while_busy"}, {31'b0, rdy_busy}, 32'd0);
    if (exp_wr) check({tag, "/mem_wdata"}, wr_seen, exp_wdata);
    @(posedge clock); #1;
    check({tag, "/resp_one_cycle"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[32'h10 >> 2] = 32'h8899_AABB;
    ram[32'h30 >> 2] = 32'h5566_7788;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #12;
    check("rst/ready", {31'b0, req_ready}, 32'd1);
    check("rst/resp", {30'b0, resp_valid, resp_err}, 32'd0);
    check("rst/strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst/load_data", load_data, 32'd0);
    check("rst/mem_addr", mem_addr, 32'd0);
    check("rst/mem_wdata", mem_wdata, 32'd0);
    @(negedge clock); reset_n = 1'b1;

    //      tag     w     sz     sg    addr   wdata          lat err  load_data      rd    wr    wdata
    run_req("lb11",  1'b0, 2'b00, 1'b1, 32'h11, 32'h0,          2, 1'b0, 32'hFFFF_FF99, 1'b1, 1'b0, 32'h0);
    run_req("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,          2, 1'b0, 32'h0000_00BB, 1'b1, 1'b0, 32'h0);
    run_req("lbu10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0,          2, 1'b0, 32'h0000_0088, 1'b1, 1'b0, 32'h0);
    run_req("lhu12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,          2, 1'b0, 32'h0000_AABB, 1'b1, 1'b0, 32'h0);
    run_req("lh10",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0,          2, 1'b0, 32'hFFFF_8899, 1'b1, 1'b0, 32'h0);
    run_req("sb12",  1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00CC,  3, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8899_CCBB);
    run_req("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,          2, 1'b0, 32'h8899_CCBB, 1'b1, 1'b0, 32'h0);
    run_req("sw20",  1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF,  2, 1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF);
    run_req("lw20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,          2, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    run_req("lh21",  1'b0, 2'b01, 1'b1, 32'h21, 32'h0,          1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0);
    run_req("sw22",  1'b1, 2'b10, 1'b0, 32'h22, 32'h1111_2222,  1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0);
    run_req("sz11",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0,          1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0);
    check("ram20", ram[32'h20 >> 2], 32'hDEAD_BEEF);
    check("ram10", ram[32'h10 >> 2], 32'h8899_CCBB);

    // Half store at 0x30 aborted by reset while its write cycle is active.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h0000_1234;
    @(posedge clock); #1; req_valid = 1'b0;
    @(posedge clock); #1;
    check("abort/in_wr", {31'b0, mem_write}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort/mem_write", {31'b0, mem_write}, 32'd0);
    check("abort/ready", {31'b0, req_ready}, 32'd1);
    check("abort/resp", {31'b0, resp_valid}, 32'd0);
    @(posedge clock); #1;
    check("abort/ram30", ram[32'h30 >> 2], 32'h5566_7788);
    @(negedge clock); reset_n = 1'b1;
    run_req("lw30",  1'b0, 2'b10, 1'b0, 32'h30, 32'h0,          2, 1'b0, 32'h5566_7788, 1'b1, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
